gnr_attractor_ctrl: RTL and testbench
=====================================

# gnr_attractor_ctrl

Sequencer for the node array of a gene-regulatory-network (GNR) accelerator. It drives the shared node control lines (`reset_nos`, `start_s0`, `start_s1`, `init_state`) and reads back both node state copies. From an initial state it finds the attractor by Floyd cycle detection. It reports the cycle length (period), the transient length, and one attractor state. It sits between the host-facing job interface and the array of per-node modules.

## Interface
Parameters:
- `N_NODES`, default 8: number of network nodes, which is the width of the state vectors.
- `CNT_W`, default 16: width of the step counters and of the period/transient results.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: job request; sampled only in IDLE.
- `init_vec`, in, N_NODES: initial network state; sampled when `start` is accepted.
- `s0_vec`, in, N_NODES: concatenated node s0 (tortoise) outputs.
- `s1_vec`, in, N_NODES: concatenated node s1 (hare) outputs.
- `reset_nos`, out, 1: loads `init_state` into both copies of every node and sets each node's pass flag to 1.
- `init_state`, out, N_NODES: per-node load value.
- `start_s0`, out, 1: tortoise step enable. Nodes update s0 only on every second asserted cycle, starting with the first one after `reset_nos`.
- `start_s1`, out, 1: hare step enable. Nodes update s1 on every asserted cycle.
- `busy`, out, 1: job in progress.
- `done`, out, 1: result valid; held until the next accepted `start`.
- `timeout`, out, 1: a counter saturated before the search finished; valid with `done`.
- `period`, out, CNT_W: attractor length λ (≥1).
- `transient`, out, CNT_W: steps from `init_vec` to the first attractor state, μ.
- `attr_state`, out, N_NODES: the s0 state captured at the first meeting.

## Operation
- Node outputs are registered. A step enabled in cycle t is visible on `s*_vec` in cycle t+1. `eq` is `s0_vec == s1_vec`, evaluated combinationally each cycle.
- The controller keeps `pmir`, a mirror of the node pass flag. `pmir` is set to 1 with `reset_nos` and toggles on every cycle with `start_s0`=1.
- State machine:
  - IDLE: `start` → LOAD. Clears `done` and `timeout`, latches `init_vec`, sets `busy`.
  - LOAD: `reset_nos`=1 for 1 cycle, `init_state`=latched vector, `k`=0 → RUN.
  - RUN: if `k` is even, `k`>0 and `eq`: no starts, capture `attr_state`=`s0_vec`, `lam`=0 → PERIOD. Otherwise `start_s0`=`start_s1`=1 and `k`++.
  - PERIOD: if `lam`>0 and `eq`: no starts, `period`=`lam` → LOAD2. Otherwise `start_s1`=1 only, `lam`++.
  - LOAD2: `reset_nos`=1 for 1 cycle with the same vector, `adv`=0 → ADVANCE.
  - ADVANCE: `start_s1`=1 while `adv`<`period`, `adv`++. When `adv`==`period`: no start → SYNC, `mu`=0.
  - SYNC, `pmir`=1: if `eq`: `transient`=`mu` → FIN. Otherwise `start_s0`=`start_s1`=1, `mu`++.
  - SYNC, `pmir`=0: `start_s0`=1 only (consumes the node pass phase, no state change), no compare.
  - FIN: `done`=1, `busy`=0 → IDLE.
- Counters `k`, `lam`, `adv` and `mu` are CNT_W bits. If any counter reaches 2^CNT_W−1 while it would still increment, go to FIN with `timeout`=1. In that case `period` and `transient` hold the partial values reached so far.
- `start_s0` and `start_s1` are never asserted in the same cycle as `reset_nos`.
- `start` asserted while `busy` is ignored.

## Timing
- Reset values: `reset_nos`, `start_s0`, `start_s1`, `busy`, `done` and `timeout` are 0. `init_state`, `period`, `transient` and `attr_state` are 0. State is IDLE, `pmir`=1.
- `rst` mid-job: the controller returns to IDLE on the next edge with all outputs at their reset values. No further node strobes are issued.
- `start` accepted at edge e: `reset_nos` is high in the cycle after e.
- For a fixed-point initial state (`f(x)=x`): RUN sees `eq` at `k`=2, which sets λ=1. SYNC matches at `mu`=0, which sets μ=0.
- All control outputs are Moore/Mealy functions of registered state and the current `eq`. There is no extra cycle between a compare and the decision.
- Total latency is about 2·k_meet + λ + λ + 2μ + 5 cycles. The bench checks results, not the exact cycle count, except in scenario 1.

## Test plan
- Fixed point: bench node model with f(x)=x, `init_vec`=0x05. Expect `period`=1, `transient`=0, `attr_state`=0x05, `timeout`=0. `done` rises exactly 11 cycles after `start` is accepted.
- Rho chain: f is 0→1→2→3→4→5→3. With `init_vec`=0, expect `period`=3, `transient`=3, `attr_state` in {3,4,5}.
- Pure cycle: f(x)=(x+1) mod 7, `init_vec`=2. Expect `period`=7, `transient`=0.
- Timeout: CNT_W=4, f(x)=(x+1) mod 20. Expect `done`=1 with `timeout`=1, and no node strobes after `done`.
- Mid-job reset: assert `rst` during PERIOD. Next cycle: `busy`=0, all strobes 0. A new `start` then yields the correct rho-chain result (3, 3).
- Protocol check: on every cycle, assert that `reset_nos` is never concurrent with a start strobe. Also assert that in SYNC, `start_s1` is high only when `pmir`=1.

Source files
------------

// File: rtl/gnr_attractor_ctrl_if.sv
// Job and node-array signals of the GNR attractor sequencer.
// The master side is the controller; the slave side is the host and the node array.
interface gnr_attractor_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [N_NODES-1:0] init_vec;
  logic [N_NODES-1:0] s0_vec;
  logic [N_NODES-1:0] s1_vec;
  logic               reset_nos;
  logic [N_NODES-1:0] init_state;
  logic               start_s0;
  logic               start_s1;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   transient;
  logic [N_NODES-1:0] attr_state;

  modport master (
    input  start, init_vec, s0_vec, s1_vec,
    output reset_nos, init_state, start_s0, start_s1,
           busy, done, timeout, period, transient, attr_state
  );

  modport slave (
    output start, init_vec, s0_vec, s1_vec,
    input  reset_nos, init_state, start_s0, start_s1,
           busy, done, timeout, period, transient, attr_state
  );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Floyd attractor search over the GNR node array: finds the meeting point,
// then the period, then the transient.
module gnr_attractor_ctrl #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gnr_attractor_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_PERIOD, S_LOAD2, S_ADV, S_SYNC, S_FIN
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t             r_state;
  logic [N_NODES-1:0] r_vec;
  logic [N_NODES-1:0] r_attr;
  logic [CNT_W-1:0]   r_k, r_lam, r_adv, r_mu;
  logic [CNT_W-1:0]   r_period, r_transient;
  logic               r_pmir, r_busy, r_done, r_timeout;

  logic w_eq, w_meet, w_reset_nos, w_s0, w_s1;

  assign w_eq   = (bus.s0_vec == bus.s1_vec);
  // Only even k puts the tortoise at exactly x[k/2]; k=0 is the trivial match.
  assign w_meet = !r_k[0] && (r_k != '0) && w_eq;

  // Strobes react to the current compare so no cycle is lost between
  // a match and the decision.
  always_comb begin
    w_reset_nos = (r_state == S_LOAD) || (r_state == S_LOAD2);
    w_s0        = 1'b0;
    w_s1        = 1'b0;
    case (r_state)
      S_RUN: if (!w_meet && r_k != CMAX) begin
        w_s0 = 1'b1;
        w_s1 = 1'b1;
      end
      S_PERIOD: if (!((r_lam != '0) && w_eq) && r_lam != CMAX) w_s1 = 1'b1;
      S_ADV:    if (r_adv != r_period) w_s1 = 1'b1;
      S_SYNC: begin
        if (r_pmir) begin
          if (!w_eq && r_mu != CMAX) begin
            w_s0 = 1'b1;
            w_s1 = 1'b1;
          end
        end else begin
          w_s0 = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      w_reset_nos = 1'b0;
      w_s0        = 1'b0;
      w_s1        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vec       <= '0;
      r_attr      <= '0;
      r_k         <= '0;
      r_lam       <= '0;
      r_adv       <= '0;
      r_mu        <= '0;
      r_period    <= '0;
      r_transient <= '0;
      r_pmir      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // Mirror of the node pass flag: only odd-numbered s0 strobes move s0.
      if (w_reset_nos)  r_pmir <= 1'b1;
      else if (w_s0)    r_pmir <= ~r_pmir;

      case (r_state)
        S_IDLE: if (bus.start) begin
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
          r_vec     <= bus.init_vec;
          r_busy    <= 1'b1;
          r_state   <= S_LOAD;
        end
        S_LOAD: begin
          r_k     <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_meet) begin
            r_attr  <= bus.s0_vec;
            r_lam   <= '0;
            r_state <= S_PERIOD;
          end else if (r_k == CMAX) begin
            r_timeout <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_PERIOD: begin
          if ((r_lam != '0) && w_eq) begin
            r_period <= r_lam;
            r_state  <= S_LOAD2;
          end else if (r_lam == CMAX) begin
            r_period  <= r_lam;
            r_timeout <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_lam <= r_lam + 1'b1;
          end
        end
        S_LOAD2: begin
          r_adv   <= '0;
          r_state <= S_ADV;
        end
        S_ADV: begin
          if (r_adv == r_period) begin
            r_mu    <= '0;
            r_state <= S_SYNC;
          end else begin
            r_adv <= r_adv + 1'b1;
          end
        end
        S_SYNC: if (r_pmir) begin
          if (w_eq) begin
            r_transient <= r_mu;
            r_state     <= S_FIN;
          end else if (r_mu == CMAX) begin
            r_transient <= r_mu;
            r_timeout   <= 1'b1;
            r_state     <= S_FIN;
          end else begin
            r_mu <= r_mu + 1'b1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.reset_nos  = w_reset_nos;
  assign bus.start_s0   = w_s0;
  assign bus.start_s1   = w_s1;
  assign bus.init_state = r_vec;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.timeout    = r_timeout;
  assign bus.period     = r_period;
  assign bus.transient  = r_transient;
  assign bus.attr_state = r_attr;
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: table-driven node array model, sequence-walk
// reference for (period, transient), and a per-cycle protocol monitor.
module tb_gnr_attractor_ctrl;
  localparam int NN = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gnr_attractor_ctrl_if #(.N_NODES(NN), .CNT_W(CW)) bus ();
  gnr_attractor_ctrl_if #(.N_NODES(NN), .CNT_W(4))  bus4 ();

  gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // node array model: next-state function is a lookup table
  logic [7:0] ftab [256];
  logic [7:0] n_s0 = '0, n_s1 = '0;
  logic       n_p  = 1'b1;
  always @(posedge clk) begin
    if (bus.reset_nos) begin
      n_s0 <= bus.init_state; n_s1 <= bus.init_state; n_p <= 1'b1;
    end else begin
      if (bus.start_s1) n_s1 <= ftab[n_s1];
      if (bus.start_s0) begin
        if (n_p) n_s0 <= ftab[n_s0];
        n_p <= ~n_p;
      end
    end
  end
  assign bus.s0_vec = n_s0;
  assign bus.s1_vec = n_s1;

  // second node array for the narrow-counter instance: f(x) = (x+1) mod 20
  function automatic logic [7:0] f20(input logic [7:0] x);
    return (x >= 8'd19) ? 8'd0 : x + 8'd1;
  endfunction
  logic [7:0] m_s0 = '0, m_s1 = '0;
  logic       m_p  = 1'b1;
  always @(posedge clk) begin
    if (bus4.reset_nos) begin
      m_s0 <= bus4.init_state; m_s1 <= bus4.init_state; m_p <= 1'b1;
    end else begin
      if (bus4.start_s1) m_s1 <= f20(m_s1);
      if (bus4.start_s0) begin
        if (m_p) m_s0 <= f20(m_s0);
        m_p <= ~m_p;
      end
    end
  end
  assign bus4.s0_vec = m_s0;
  assign bus4.s1_vec = m_s1;

  int n_chk = 0, n_pass = 0;
  int mon_chk = 0, mon_pass = 0;
  int nload = 0;

  // protocol monitor; after the second load of a job the controller is in ADVANCE/SYNC
  always @(negedge clk) begin
    if (bus.reset_nos || bus.start_s0 || bus.start_s1) begin
      mon_chk++;
      if (bus.reset_nos && (bus.start_s0 || bus.start_s1))
        $display("FAIL proto_reset_excl: reset_nos=1 with s0=%0b s1=%0b required no strobe",
                 bus.start_s0, bus.start_s1);
      else mon_pass++;
    end
    if (nload == 2 && bus.start_s0) begin
      mon_chk++;
      if (bus.start_s1 !== n_p)
        $display("FAIL proto_sync_phase: start_s1=%0b required %0b (pass flag)", bus.start_s1, n_p);
      else mon_pass++;
    end
    if (rst || !bus.busy) nload = 0;
    else if (bus.reset_nos) nload++;
  end

  // reference: walk the sequence, first repeat gives mu and lambda
  int m_idx [256];
  task automatic model(input logic [7:0] init, output int mu, output int lam);
    logic [7:0] x;
    mu = 0; lam = 0;
    for (int i = 0; i < 256; i++) m_idx[i] = -1;
    x = init;
    for (int i = 0; i < 300; i++) begin
      if (m_idx[x] >= 0) begin
        mu = m_idx[x]; lam = i - m_idx[x];
        break;
      end
      m_idx[x] = i;
      x = ftab[x];
    end
  endtask

  task automatic run_job(input logic [7:0] init, output int cyc, output bit got);
    @(negedge clk); bus.init_vec = init; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      if (bus.done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000",
               {bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout});
    else n_pass++;
    n_chk++;
    if ({bus.period, bus.transient, bus.init_state, bus.attr_state} !== '0)
      $display("FAIL reset_data: period=%0d transient=%0d init=%0h attr=%0h required all 0",
               bus.period, bus.transient, bus.init_state, bus.attr_state);
    else n_pass++;
    n_chk++;
    if ({bus4.busy, bus4.done, bus4.timeout, bus4.start_s0, bus4.start_s1} !== 5'b0)
      $display("FAIL reset_narrow: got %b required 00000",
               {bus4.busy, bus4.done, bus4.timeout, bus4.start_s0, bus4.start_s1});
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fixed_point();
    int cyc; bit got;
    for (int i = 0; i < 256; i++) ftab[i] = 8'(i);
    run_job(8'h05, cyc, got);
    n_chk++; if (!got) $display("FAIL fp_done: no done within budget"); else n_pass++;
    n_chk++; if (cyc != 11) $display("FAIL fp_latency: got %0d cycles required 11", cyc); else n_pass++;
    n_chk++; if (bus.period !== 16'd1) $display("FAIL fp_period: got %0d required 1", bus.period); else n_pass++;
    n_chk++; if (bus.transient !== 16'd0) $display("FAIL fp_transient: got %0d required 0", bus.transient); else n_pass++;
    n_chk++; if (bus.attr_state !== 8'h05) $display("FAIL fp_attr: got %0h required 05", bus.attr_state); else n_pass++;
    n_chk++; if (bus.timeout !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL fp_flags: timeout=%0b busy=%0b required 0 0", bus.timeout, bus.busy); else n_pass++;
  endtask

  task automatic set_rho();
    for (int i = 0; i < 256; i++) ftab[i] = (i < 5) ? 8'(i + 1) : ((i == 5) ? 8'd3 : 8'd0);
  endtask

  task automatic test_rho();
    int cyc; bit got;
    set_rho();
    run_job(8'h00, cyc, got);
    n_chk++; if (!got) $display("FAIL rho_done: no done within budget"); else n_pass++;
    n_chk++; if (bus.period !== 16'd3) $display("FAIL rho_period: got %0d required 3", bus.period); else n_pass++;
    n_chk++; if (bus.transient !== 16'd3) $display("FAIL rho_transient: got %0d required 3", bus.transient); else n_pass++;
    n_chk++;
    if (!(bus.attr_state inside {8'd3, 8'd4, 8'd5}))
      $display("FAIL rho_attr: got %0d required one of 3,4,5", bus.attr_state);
    else n_pass++;
  endtask

  task automatic test_pure_cycle();
    int cyc; bit got;
    for (int i = 0; i < 256; i++) ftab[i] = 8'((i < 7) ? (i + 1) % 7 : i % 7);
    run_job(8'h02, cyc, got);
    n_chk++; if (!got) $display("FAIL cyc_done: no done within budget"); else n_pass++;
    n_chk++; if (bus.period !== 16'd7) $display("FAIL cyc_period: got %0d required 7", bus.period); else n_pass++;
    n_chk++; if (bus.transient !== 16'd0) $display("FAIL cyc_transient: got %0d required 0", bus.transient); else n_pass++;
  endtask

  task automatic test_random();
    int cyc, mu, lam, m; bit got; logic [7:0] init;
    for (int it = 0; it < 10; it++) begin
      m = int'($urandom_range(2, 40));
      for (int i = 0; i < 256; i++) ftab[i] = 8'($urandom_range(0, m - 1));
      init = 8'($urandom_range(0, 255));
      model(init, mu, lam);
      run_job(init, cyc, got);
      n_chk++; if (!got) $display("FAIL rnd_done[%0d]: no done within budget", it); else n_pass++;
      n_chk++; if (bus.period !== 16'(lam))
        $display("FAIL rnd_period[%0d]: got %0d required %0d", it, bus.period, lam); else n_pass++;
      n_chk++; if (bus.transient !== 16'(mu))
        $display("FAIL rnd_transient[%0d]: got %0d required %0d", it, bus.transient, mu); else n_pass++;
      n_chk++; if (m_idx[bus.attr_state] < mu)
        $display("FAIL rnd_attr[%0d]: got %0h not on the cycle (mu=%0d)", it, bus.attr_state, mu); else n_pass++;
      n_chk++; if (bus.timeout !== 1'b0)
        $display("FAIL rnd_timeout[%0d]: got %0b required 0", it, bus.timeout); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit got;
    set_rho();
    @(negedge clk); bus.init_vec = 8'h00; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL b2b_accept: done=%0b busy=%0b required 0 1", bus.done, bus.busy); else n_pass++;
    // a start while busy, with a different vector, must not disturb the job
    repeat (4) @(negedge clk);
    bus.init_vec = 8'h04; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      if (bus.done) got = 1'b1;
    end
    n_chk++; if (!got) $display("FAIL b2b_done: no done within budget"); else n_pass++;
    n_chk++; if (bus.transient !== 16'd3 || bus.period !== 16'd3)
      $display("FAIL b2b_ignore: got (%0d,%0d) required (3,3)", bus.period, bus.transient); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.done !== 1'b1) $display("FAIL b2b_hold: done=%0b required 1", bus.done); else n_pass++;
    run_job(8'h04, cyc, got);
    n_chk++; if (!got || bus.period !== 16'd3 || bus.transient !== 16'd0)
      $display("FAIL b2b_second: got (%0d,%0d) required (3,0)", bus.period, bus.transient); else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc; bit got, seen;
    @(negedge clk); bus4.init_vec = 8'h00; bus4.start = 1'b1;
    @(posedge clk); #1; bus4.start = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 500) begin
      @(posedge clk); cyc++; #1;
      if (bus4.done) got = 1'b1;
    end
    n_chk++; if (!got) $display("FAIL to_done: no done within budget"); else n_pass++;
    n_chk++; if (bus4.timeout !== 1'b1 || bus4.busy !== 1'b0)
      $display("FAIL to_flag: timeout=%0b busy=%0b required 1 0", bus4.timeout, bus4.busy); else n_pass++;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.start_s0 || bus4.start_s1 || bus4.reset_nos) seen = 1'b1;
    end
    n_chk++; if (seen) $display("FAIL to_quiet: strobe seen after done, required none"); else n_pass++;
  endtask

  task automatic test_midjob_reset();
    int cyc, w; bit got, seen;
    set_rho();
    @(negedge clk); bus.init_vec = 8'h00; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    w = 0;
    while (!(bus.start_s1 && !bus.start_s0 && !bus.reset_nos) && w < 200) begin
      @(negedge clk); w++;
    end
    n_chk++; if (w >= 200) $display("FAIL mr_period: PERIOD phase not seen within budget"); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({bus.busy, bus.done, bus.start_s0, bus.start_s1, bus.reset_nos} !== 5'b0)
      $display("FAIL mr_idle: busy/done/s0/s1/rn=%b required 00000",
               {bus.busy, bus.done, bus.start_s0, bus.start_s1, bus.reset_nos}); else n_pass++;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.start_s0 || bus.start_s1 || bus.reset_nos) seen = 1'b1;
    end
    n_chk++; if (seen) $display("FAIL mr_quiet: strobe after reset, required none"); else n_pass++;
    run_job(8'h00, cyc, got);
    n_chk++; if (!got || bus.period !== 16'd3 || bus.transient !== 16'd3)
      $display("FAIL mr_rerun: got (%0d,%0d) required (3,3)", bus.period, bus.transient); else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;  bus.init_vec = '0;
    bus4.start = 1'b0; bus4.init_vec = '0;
    for (int i = 0; i < 256; i++) ftab[i] = 8'(i);
    test_reset();
    test_fixed_point();
    test_rho();
    test_pure_cycle();
    test_random();
    test_back_to_back();
    test_timeout();
    test_midjob_reset();
    @(posedge clk);
    n_chk  += mon_chk;
    n_pass += mon_pass;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
